// File: rtl/rsa_mont_exp_pkg.sv
// Shared types for the RSA modular-exponentiation controller.
// Operand bundles travel as flat vectors in {msg_mont, key, modulus} / {a, b, modulus} order.
package rsa_mont_exp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    WAIT_MUL,
    SQR,
    WAIT_SQR,
    DONE
  } rsa_exp_state_e;

  function automatic int cnt_width(int key_width);
    return $clog2(key_width + 1);
  endfunction

endpackage

// File: rtl/rsa_mont_exp.sv
// LSB-first square-and-multiply driving an external Montgomery multiplier.
// acc stays in the plain domain, sq in Montgomery form, so the result needs no conversion.
module rsa_mont_exp
  import rsa_mont_exp_pkg::*;
#(
  parameter int MOD_WIDTH = 256,
  parameter int KEY_WIDTH = MOD_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_valid,
  output logic                             i_ready,
  input  logic [2*MOD_WIDTH+KEY_WIDTH-1:0] i_in,
  output logic                             o_valid,
  input  logic                             o_ready,
  output logic [MOD_WIDTH-1:0]             o_out,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [3*MOD_WIDTH-1:0]           m_in,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [MOD_WIDTH-1:0]             s_out
);

  localparam int CW = cnt_width(KEY_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(KEY_WIDTH - 1);

  rsa_exp_state_e state_q, state_d;

  logic [MOD_WIDTH-1:0] acc, sq, mod_r;
  logic [KEY_WIDTH-1:0] key_r, key_nxt;
  logic [CW-1:0]        bit_cnt;

  logic [MOD_WIDTH-1:0] in_msg, in_mod;
  logic [KEY_WIDTH-1:0] in_key;

  assign in_msg  = i_in[2*MOD_WIDTH+KEY_WIDTH-1 -: MOD_WIDTH];
  assign in_key  = i_in[MOD_WIDTH+KEY_WIDTH-1 -: KEY_WIDTH];
  assign in_mod  = i_in[MOD_WIDTH-1:0];
  // key_r shifts right per squaring; bit 1 is the next exponent bit
  assign key_nxt = key_r >> 1;

  assign i_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign o_out   = acc;
  assign m_valid = (state_q == MUL) || (state_q == SQR);
  assign s_ready = (state_q == WAIT_MUL) || (state_q == WAIT_SQR);
  assign m_in    = {(state_q == MUL) ? acc : sq, sq, mod_r};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (i_valid) state_d = in_key[0] ? MUL : SQR;
      MUL:      if (m_ready) state_d = WAIT_MUL;
      WAIT_MUL: if (s_valid) state_d = SQR;
      SQR:      if (m_ready) state_d = WAIT_SQR;
      WAIT_SQR: begin
        if (s_valid) begin
          if (bit_cnt == LAST) state_d = DONE;
          else                 state_d = key_nxt[0] ? MUL : SQR;
        end
      end
      DONE:     if (o_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc     <= '0;
      sq      <= '0;
      key_r   <= '0;
      mod_r   <= '0;
      bit_cnt <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (i_valid) begin
            acc     <= MOD_WIDTH'(1);
            sq      <= in_msg;
            key_r   <= in_key;
            mod_r   <= in_mod;
            bit_cnt <= '0;
          end
        end
        WAIT_MUL: if (s_valid) acc <= s_out;
        WAIT_SQR: begin
          if (s_valid) begin
            sq      <= s_out;
            key_r   <= key_nxt;
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_mont_exp.sv
// Bench for rsa_mont_exp with an 8-bit modulus and a random-latency Montgomery model.
// Expected results are pushed at request time and popped when the DUT presents o_out.
module tb_rsa_mont_exp;

  localparam int MW = 8;
  localparam int KW = 8;
  localparam int N  = 187;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_valid = 1'b0;
  logic              i_ready;
  logic [2*MW+KW-1:0] i_in = '0;
  logic              o_valid;
  logic              o_ready = 1'b0;
  logic [MW-1:0]     o_out;
  logic              m_valid;
  logic              m_ready;
  logic [3*MW-1:0]   m_in;
  logic              s_valid;
  logic              s_ready;
  logic [MW-1:0]     s_out;

  int n_vec = 0;
  int n_err = 0;
  int ops   = 0;
  int exp_q[$];
  int ops_q[$];

  always #5 clk = ~clk;

  rsa_mont_exp #(.MOD_WIDTH(MW), .KEY_WIDTH(KW)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_in(i_in),
    .o_valid(o_valid), .o_ready(o_ready), .o_out(o_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_in(m_in),
    .s_valid(s_valid), .s_ready(s_ready), .s_out(s_out)
  );

  task automatic chk(string tag, int got, int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rinv();
    for (int x = 1; x < N; x++)
      if ((256 * x) % N == 1) return x;
    return 0;
  endfunction

  function automatic int mont(int a, int b);
    return (((a * b) % N) * rinv()) % N;
  endfunction

  function automatic int modexp(int msg, int key);
    int r, b;
    r = 1;
    b = msg % N;
    for (int i = 0; i < KW; i++) begin
      if ((key >> i) & 1) r = (r * b) % N;
      b = (b * b) % N;
    end
    return r;
  endfunction

  function automatic int popcnt(int key);
    int c;
    c = 0;
    for (int i = 0; i < KW; i++) c += (key >> i) & 1;
    return c;
  endfunction

  // Montgomery multiplier model: random accept stalls, 1-20 cycle latency
  logic busy;
  int   lat;
  always @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      m_ready <= 1'b0;
      s_valid <= 1'b0;
      s_out   <= '0;
      lat     <= 0;
    end else if (!busy) begin
      m_ready <= 1'($urandom_range(0, 1));
      if (m_valid && m_ready) begin
        busy    <= 1'b1;
        m_ready <= 1'b0;
        s_out   <= MW'(mont(int'(m_in[3*MW-1 -: MW]), int'(m_in[2*MW-1 -: MW])));
        lat     <= int'($urandom_range(1, 20));
        ops     <= ops + 1;
      end
    end else if (!s_valid) begin
      if (lat <= 1) s_valid <= 1'b1;
      lat <= lat - 1;
    end else if (s_ready) begin
      s_valid <= 1'b0;
      busy    <= 1'b0;
    end
  end

  // Request payload must hold while stalled; request and response never overlap
  logic            prev_stall = 1'b0;
  logic [3*MW-1:0] prev_m_in  = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", int'(m_valid), 1);
        chk("stall_m_in", int'(m_in), int'(prev_m_in));
      end
      if (m_valid && s_ready) chk("m_valid_s_ready_excl", 1, 0);
      prev_stall <= m_valid && !m_ready;
      prev_m_in  <= m_in;
    end
  end

  int ops_base;

  task automatic start(int msg, int key);
    int mm, t;
    mm = (msg * 256) % N;
    t = 0;
    @(negedge clk);
    while (!i_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("i_ready_wait", int'(i_ready), 1);
    i_in    = {MW'(mm), KW'(key), MW'(N)};
    i_valid = 1'b1;
    @(negedge clk);
    i_valid  = 1'b0;
    ops_base = ops;
    exp_q.push_back(modexp(msg, key));
    ops_q.push_back(KW + popcnt(key));
  endtask

  task automatic finish(int hold);
    int t, e, eo;
    t = 0;
    while (!o_valid && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("o_valid_timeout", int'(o_valid), 1);
    e  = exp_q.pop_front();
    eo = ops_q.pop_front();
    chk("result", int'(o_out), e);
    chk("op_count", ops - ops_base, eo);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_o_valid", int'(o_valid), 1);
      chk("hold_o_out", int'(o_out), e);
      chk("hold_i_ready", int'(i_ready), 0);
    end
    o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
    chk("post_o_valid", int'(o_valid), 0);
    chk("post_i_ready", int'(i_ready), 1);
  endtask

  initial begin
    int t, msg, key;
    repeat (3) @(negedge clk);
    chk("rst_i_ready", int'(i_ready), 1);
    chk("rst_o_valid", int'(o_valid), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_s_ready", int'(s_ready), 0);
    rst = 1'b0;

    start(2, 3);  finish(0);
    start(5, 3);  finish(0);
    start(2, 0);  finish(0);
    start(2, 7);  finish(10);

    for (int k = 0; k < 4; k++) begin
      msg = int'($urandom_range(0, N - 1));
      key = int'($urandom_range(0, 255));
      start(msg, key);
      finish(0);
    end

    // key=0 runs only squarings, so any s_ready means WAIT_SQR
    start(3, 0);
    t = 0;
    while (!s_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("reach_wait_sqr", int'(s_ready), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_i_ready", int'(i_ready), 1);
    chk("mid_rst_o_valid", int'(o_valid), 0);
    chk("mid_rst_m_valid", int'(m_valid), 0);
    chk("mid_rst_s_ready", int'(s_ready), 0);
    void'(exp_q.pop_front());
    void'(ops_q.pop_front());
    start(5, 3);  finish(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
